// File: rtl/dwell_seq_pkg.sv
// Shared definitions for the radar dwell sequencer: state encoding and default sizing.
package dwell_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam int unsigned N_MODES_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 19;
    localparam int unsigned IL_W_DEF    = 2;
    // 1.5 ms field at a 50 ns clock
    localparam int unsigned DWELL_1P5MS = 30000;

endpackage

// File: rtl/dwell_sequencer_if.sv
// Control/status bundle between a host and the dwell sequencer.
interface dwell_sequencer_if #(
    parameter int unsigned N_MODES = dwell_seq_pkg::N_MODES_DEF,
    parameter int unsigned CNT_W   = dwell_seq_pkg::CNT_W_DEF,
    parameter int unsigned IL_W    = dwell_seq_pkg::IL_W_DEF
);
    localparam int unsigned IDX_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;

    logic [N_MODES-1:0] selector;
    logic               tx_on;
    logic [CNT_W-1:0]   dwell;
    logic [IL_W-1:0]    interlace;
    logic               repeat_en;
    logic               abort;
    logic [N_MODES-1:0] mode;
    logic [IDX_W-1:0]   mode_idx;
    logic               oddeven;
    logic               stop;
    logic               done;
    logic               busy;

    modport master (
        output selector, tx_on, dwell, interlace, repeat_en, abort,
        input  mode, mode_idx, oddeven, stop, done, busy
    );

    modport slave (
        input  selector, tx_on, dwell, interlace, repeat_en, abort,
        output mode, mode_idx, oddeven, stop, done, busy
    );
endinterface

// File: rtl/dwell_sequencer_lowbit_pick.sv
// Combinational lowest-set-bit picker: one-hot result, its index, and an empty flag.
module lowbit_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec_i,
    output logic [N-1:0]     onehot_c_o,
    output logic [IDX_W-1:0] idx_c_o,
    output logic             none_c_o
);

    // Two's-complement trick isolates the lowest set bit; the scan walks down so the lowest wins.
    always_comb begin
        onehot_c_o = vec_i & (~vec_i + N'(1));
        none_c_o   = ~|vec_i;
        idx_c_o    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_c_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/dwell_sequencer.sv
// Steps through the enabled radar modes, holding each for interlace fields of dwell cycles.
module dwell_sequencer
    import dwell_seq_pkg::*;
#(
    parameter int unsigned N_MODES = N_MODES_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned IL_W    = IL_W_DEF
) (
    input logic              clk,
    input logic              rst,
    dwell_sequencer_if.slave bus
);

    localparam int unsigned IDX_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;

    state_e             state_q, state_d;
    logic [N_MODES-1:0] sel_q, sel_d;
    logic [N_MODES-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [IL_W-1:0]    il_q, il_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IL_W-1:0]    field_q, field_d;
    logic [N_MODES-1:0] mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [N_MODES-1:0] pend_rem;
    logic [N_MODES-1:0] pick_in;
    logic [N_MODES-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_none;
    logic               field_end;
    logic               last_field;

    assign field_end  = (cnt_q == dwell_q - CNT_W'(1));
    assign last_field = (field_q == il_q - IL_W'(1));
    assign pend_rem   = pend_q & ~mode_q;

    // One picker serves start (raw selector), mode advance, and repeat reload.
    assign pick_in = (state_q == ST_IDLE) ? bus.selector :
                     ((pend_rem == '0) ? sel_q : pend_rem);

    lowbit_pick #(
        .N     (N_MODES),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec_i      (pick_in),
        .onehot_c_o (pick_onehot),
        .idx_c_o    (pick_idx),
        .none_c_o   (pick_none)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        dwell_d = dwell_q;
        il_d    = il_q;
        cnt_d   = cnt_q;
        field_d = field_q;
        mode_d  = mode_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (!bus.abort && bus.tx_on && !pick_none) begin
                    sel_d   = bus.selector;
                    pend_d  = bus.selector;
                    dwell_d = (bus.dwell == '0) ? CNT_W'(1) : bus.dwell;
                    il_d    = (bus.interlace == '0) ? IL_W'(1) : bus.interlace;
                    cnt_d   = '0;
                    field_d = '0;
                    mode_d  = pick_onehot;
                    idx_d   = pick_idx;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    pend_d  = '0;
                    cnt_d   = '0;
                    field_d = '0;
                    mode_d  = '0;
                    idx_d   = '0;
                end else if (field_end) begin
                    cnt_d = '0;
                    if (!last_field) begin
                        field_d = field_q + IL_W'(1);
                    end else begin
                        field_d = '0;
                        if (pend_rem != '0) begin
                            pend_d = pend_rem;
                            mode_d = pick_onehot;
                            idx_d  = pick_idx;
                        end else if (bus.repeat_en) begin
                            pend_d = sel_q;
                            mode_d = pick_onehot;
                            idx_d  = pick_idx;
                        end else begin
                            pend_d  = '0;
                            mode_d  = '0;
                            idx_d   = '0;
                            state_d = ST_FINISH;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                field_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            pend_q  <= '0;
            dwell_q <= '0;
            il_q    <= '0;
            cnt_q   <= '0;
            field_q <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            dwell_q <= dwell_d;
            il_q    <= il_d;
            cnt_q   <= cnt_d;
            field_q <= field_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.mode     = mode_q;
    assign bus.mode_idx = idx_q;
    assign bus.oddeven  = field_q[0];
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.stop     = (state_q == ST_RUN) && field_end;

endmodule

// File: tb/tb_dwell_sequencer.sv
// Directed scoreboard bench for dwell_sequencer: per-cycle expected outputs are queued, then popped and checked.
module tb_dwell_sequencer;

    logic clk;
    logic rst_n;

    dwell_sequencer_if bus_if ();

    dwell_sequencer u_dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mode;
        logic [1:0] idx;
        logic       odd;
        logic       stop;
        logic       done;
        logic       busy;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_n    = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_rec(input logic [3:0] m, input logic [1:0] i, input logic o,
                            input logic s, input logic d, input logic b);
        rec_t r;
        r.mode = m; r.idx = i; r.odd = o; r.stop = s; r.done = d; r.busy = b;
        exp_q.push_back(r);
    endtask

    // Reference behaviour for one full pass over the enabled modes.
    task automatic push_pass(input logic [3:0] sel, input int d, input int il);
        int de;
        int ie;
        de = (d == 0) ? 1 : d;
        ie = (il == 0) ? 1 : il;
        for (int m = 0; m < 4; m++) begin
            if (sel[m]) begin
                for (int f = 0; f < ie; f++) begin
                    for (int c = 0; c < de; c++) begin
                        push_rec(4'(1 << m), 2'(m), f[0], (c == de - 1), 1'b0, 1'b1);
                    end
                end
            end
        end
    endtask

    task automatic push_finish();
        push_rec(4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) push_rec(4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic trim(input int keep);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic check_one();
        rec_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow@%0d: observed empty queue required an entry", cyc_n);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("mode@%0d", cyc_n),     8'(bus_if.mode),     8'(e.mode));
            chk($sformatf("mode_idx@%0d", cyc_n), 8'(bus_if.mode_idx), 8'(e.idx));
            chk($sformatf("oddeven@%0d", cyc_n),  8'(bus_if.oddeven),  8'(e.odd));
            chk($sformatf("stop@%0d", cyc_n),     8'(bus_if.stop),     8'(e.stop));
            chk($sformatf("done@%0d", cyc_n),     8'(bus_if.done),     8'(e.done));
            chk($sformatf("busy@%0d", cyc_n),     8'(bus_if.busy),     8'(e.busy));
        end
    endtask

    task automatic drain_n(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            check_one();
        end
    endtask

    task automatic drain();
        drain_n(exp_q.size());
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mode"},     8'(bus_if.mode),     8'd0);
        chk({tag, "_mode_idx"}, 8'(bus_if.mode_idx), 8'd0);
        chk({tag, "_oddeven"},  8'(bus_if.oddeven),  8'd0);
        chk({tag, "_stop"},     8'(bus_if.stop),     8'd0);
        chk({tag, "_done"},     8'(bus_if.done),     8'd0);
        chk({tag, "_busy"},     8'(bus_if.busy),     8'd0);
    endtask

    task automatic start(input logic [3:0] sel, input int d, input int il);
        bus_if.selector  = sel;
        bus_if.dwell     = 19'(d);
        bus_if.interlace = 2'(il);
        bus_if.tx_on     = 1'b1;
        cyc();
        bus_if.tx_on = 1'b0;
        check_one();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        bus_if.selector  = '0;
        bus_if.tx_on     = 1'b0;
        bus_if.dwell     = '0;
        bus_if.interlace = '0;
        bus_if.repeat_en = 1'b0;
        bus_if.abort     = 1'b0;
        #12;
        check_all_zero("reset");
        cyc();
        rst_n = 1'b1;
        push_idle(2);
        drain();

        // Three non-adjacent modes, two fields each; inputs scrambled mid-run with tx_on held.
        push_pass(4'b1011, 5, 2);
        push_finish();
        push_idle(3);
        start(4'b1011, 5, 2);
        bus_if.selector  = 4'b0000;
        bus_if.dwell     = 19'd2;
        bus_if.interlace = 2'd0;
        bus_if.tx_on     = 1'b1;
        drain();
        bus_if.tx_on = 1'b0;

        // Empty selector with tx_on: nothing happens.
        bus_if.selector = 4'b0000;
        bus_if.tx_on    = 1'b1;
        push_idle(3);
        drain();

        // Abort in IDLE overrides a valid start request.
        bus_if.selector  = 4'b0100;
        bus_if.dwell     = 19'd5;
        bus_if.interlace = 2'd1;
        bus_if.abort     = 1'b1;
        push_idle(3);
        drain();
        bus_if.abort = 1'b0;
        bus_if.tx_on = 1'b0;
        push_idle(1);
        drain();

        // Abort mid-field during the second mode.
        push_pass(4'b0110, 5, 1);
        trim(7);
        start(4'b0110, 5, 1);
        drain_n(6);
        bus_if.abort = 1'b1;
        push_idle(4);
        drain_n(1);
        bus_if.abort = 1'b0;
        drain();

        // Abort coincident with a field end: stop still pulses, no advance.
        push_pass(4'b0110, 5, 1);
        trim(5);
        start(4'b0110, 5, 1);
        drain_n(4);
        bus_if.abort = 1'b1;
        push_idle(3);
        drain_n(1);
        bus_if.abort = 1'b0;
        drain();

        // Repeat a single mode seamlessly, then release repeat_en for one final pass end.
        bus_if.repeat_en = 1'b1;
        for (int p = 0; p < 7; p++) push_pass(4'b0100, 5, 1);
        push_finish();
        push_idle(2);
        start(4'b0100, 5, 1);
        drain_n(31);
        bus_if.repeat_en = 1'b0;
        drain();

        // Zero dwell and interlace collapse to one cycle per mode.
        push_pass(4'b1111, 0, 0);
        push_finish();
        push_idle(2);
        start(4'b1111, 0, 0);
        drain();

        // Asynchronous reset mid-run, then a fresh start from the lowest mode.
        push_pass(4'b1011, 5, 2);
        trim(8);
        start(4'b1011, 5, 2);
        drain_n(7);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        bus_if.selector = 4'b1111;
        bus_if.tx_on    = 1'b1;
        cyc();
        cyc();
        check_all_zero("held_rst");
        bus_if.tx_on = 1'b0;
        rst_n        = 1'b1;
        push_idle(2);
        drain();
        push_pass(4'b1100, 5, 1);
        push_finish();
        push_idle(1);
        start(4'b1100, 5, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dwell_sequencer.md
DWELL_SEQUENCER -- requirements
Module: dwell_sequencer

Interface
REQ-001 SHALL have parameter N_MODES, default 4: number of radar modes and selector/mode width.
REQ-002 SHALL have parameter CNT_W, default 19: dwell counter width.
REQ-003 SHALL have parameter IL_W, default 2: interlace count width.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port selector, input, N_MODES: enabled modes, bit i = mode i.
REQ-007 SHALL have port tx_on, input, 1: start request, sampled in IDLE only.
REQ-008 SHALL have port dwell, input, CNT_W: cycles per field (1.5 ms = 30000 at 50 ns).
REQ-009 SHALL have port interlace, input, IL_W: fields per mode.
REQ-010 SHALL have port repeat_en, input, 1: restart the sequence instead of finishing.
REQ-011 SHALL have port abort, input, 1: synchronous cancel.
REQ-012 SHALL have port mode, output, N_MODES: one-hot active mode, or 0 when inactive.
REQ-013 SHALL have port mode_idx, output, $clog2(N_MODES): index of the active mode.
REQ-014 SHALL have port oddeven, output, 1: field counter LSB.
REQ-015 SHALL have port stop, output, 1: one-cycle pulse at the end of each field.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at the end of the sequence.
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-018 SHALL implement the states IDLE, RUN and FINISH.
REQ-019 IDLE start rule: when tx_on=1 and selector!=0, the block SHALL latch selector (into sel_q and pend_q), dwell and interlace.
REQ-020 On the start cycle, the block SHALL enter RUN next cycle with mode = lowest set bit of selector, counter=0 and field=0.
REQ-021 IDLE with tx_on=1 and selector=0: the block SHALL stay in IDLE with no output activity.
REQ-022 Latched dwell=0 SHALL be treated as 1; latched interlace=0 SHALL be treated as 1.
REQ-023 RUN counting: the counter SHALL increment each cycle; at counter==dwell_q-1, stop=1 that cycle and the counter wraps to 0.
REQ-024 Field advance: at a field end with field<interlace_q-1, field SHALL increment.
REQ-025 Mode advance: at a field end with field==interlace_q-1, field SHALL become 0, the current bit SHALL be cleared from pend_q, and mode SHALL move to the lowest remaining set bit; non-adjacent bits SHALL be handled correctly.
REQ-026 Sequence end: when pend_q becomes empty and repeat_en=0, the block SHALL enter FINISH and mode SHALL become 0 on the same transition.
REQ-027 Repeat: when pend_q becomes empty and repeat_en=1, pend_q SHALL reload from sel_q, mode SHALL return to the lowest bit, and the block SHALL stay in RUN with no gap cycle and no done pulse.
REQ-028 FINISH SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-029 tx_on and changes to selector, dwell or interlace during RUN SHALL be ignored.
REQ-030 abort=1 in RUN or FINISH SHALL force IDLE next cycle, with mode=0, counter/field cleared and no done pulse.
REQ-031 abort SHALL take priority over a coincident field end; stop SHALL still pulse on that cycle.
REQ-032 abort in IDLE SHALL have no effect and SHALL override tx_on on the same cycle.
REQ-033 mode, mode_idx, oddeven, busy and done SHALL be registered; stop SHALL be combinational from state and counter.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE and clear all registers.
REQ-035 During reset, the outputs SHALL be mode=0, mode_idx=0, oddeven=0, stop=0, done=0 and busy=0.
REQ-036 Reset asserted mid-RUN SHALL abandon the sequence; after release the block SHALL wait for a fresh tx_on.

Structure
REQ-037 Package dwell_seq_pkg SHALL hold the state encoding, the default parameter values and the 30000-cycle dwell constant.
REQ-038 Sub-module lowbit_pick (combinational, N_MODES-wide) SHALL return the one-hot lowest set bit, its index and a none flag; it is the only sub-module.

Verification
REQ-039 selector=4'b1011, dwell=5, interlace=2, tx_on pulse -> mode 0001 then 0010 then 1000, 10 cycles each; 6 stop pulses 5 cycles apart; oddeven 0,1 per mode; done 1 cycle after the 6th stop; busy low after done.
REQ-040 selector=0 with tx_on=1 -> busy, mode, stop and done stay 0.
REQ-041 selector=4'b0110, dwell=5, interlace=1, abort at cycle 7 -> mode=0 and busy=0 next cycle, no done, no further stop.
REQ-042 selector=4'b0100, dwell=5, interlace=1, repeat_en=1 for 30 cycles then 0 -> mode 0100 throughout, stop every 5 cycles, exactly one done after repeat_en drops.
REQ-043 dwell=0, interlace=0, selector=4'b1111 -> each mode active 1 cycle, stop every cycle for 4 cycles, then done.
REQ-044 rst=0 mid-RUN -> all outputs 0 immediately; after release, a new tx_on restarts from the lowest mode.
